// File: rtl/ecg_axis_pkg.sv
// Shared constants and types for the ECG AXIS front end.
// Used by the derivative/square stage and its core.
package ecg_axis_pkg;

  localparam int DATA_W         = 32;
  localparam int SIG_W          = 16;
  localparam int DERIV_SHIFT    = 3;
  localparam int WARMUP_SAMPLES = 4;

  typedef logic signed [SIG_W-1:0] sample_t;
  typedef logic [2*SIG_W-1:0]      energy_t;

endpackage

// File: rtl/axis_derivative_square_deriv5_core.sv
// Five-point derivative core: delay line, weighted sum, /8 shift.
// Also owns the warm-up counter so the first samples emit no valid.
module deriv5_core #(
  parameter int SIG_W           = 16,
  parameter bit SUPPRESS_WARMUP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_accept,
  input  logic signed [SIG_W-1:0] i_x,
  output logic signed [SIG_W-1:0] o_d,
  output logic                    o_v
);
  import ecg_axis_pkg::*;

  localparam int SUM_W = SIG_W + 3;

  logic signed [SIG_W-1:0] r_x1, r_x2, r_x3, r_x4;
  logic signed [SIG_W-1:0] r_d;
  logic                    r_v;
  logic [2:0]              r_warm;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shr;
  logic signed [SIG_W-1:0] w_d;
  logic                    w_warm_ok;

  assign w_sum = (SUM_W'(i_x) <<< 1)
               + SUM_W'(r_x1)
               - SUM_W'(r_x3)
               - (SUM_W'(r_x4) <<< 1);

  assign w_shr = w_sum >>> DERIV_SHIFT;
  assign w_d   = SIG_W'(w_shr);

  assign w_warm_ok = !SUPPRESS_WARMUP
                  || (r_warm >= 3'(WARMUP_SAMPLES));

  // Delay line and warm-up counter move only on an accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1   <= '0;
      r_x2   <= '0;
      r_x3   <= '0;
      r_x4   <= '0;
      r_warm <= '0;
    end else if (i_accept) begin
      r_x1 <= i_x;
      r_x2 <= r_x1;
      r_x3 <= r_x2;
      r_x4 <= r_x3;
      if (r_warm < 3'(WARMUP_SAMPLES))
        r_warm <= r_warm + 3'd1;
    end
  end

  // S1 register: derivative plus valid, bubbles when nothing accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= '0;
      r_v <= 1'b0;
    end else if (i_en) begin
      r_d <= w_d;
      r_v <= i_accept && w_warm_ok;
    end
  end

  assign o_d = r_d;
  assign o_v = r_v;

endmodule

// File: rtl/axis_derivative_square.sv
// Pan-Tompkins derivative-and-square stage with AXIS in/out.
// Whole pipeline advances together; a stalled output freezes it.
module axis_derivative_square #(
  parameter int DATA_W          = ecg_axis_pkg::DATA_W,
  parameter int SIG_W           = ecg_axis_pkg::SIG_W,
  parameter bit SUPPRESS_WARMUP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);
  import ecg_axis_pkg::*;

  logic                      r_tvalid;
  logic [DATA_W-1:0]         r_tdata;
  logic [2*SIG_W-1:0]        r_sq;
  logic                      r_v2;
  logic                      w_en;
  logic                      w_accept;
  logic signed [SIG_W-1:0]   w_x;
  logic signed [SIG_W-1:0]   w_d;
  logic                      w_v1;
  logic signed [2*SIG_W-1:0] w_prod;
  logic                      w_unused_hi;

  assign w_en          = !r_tvalid || m_axis_tready;
  assign s_axis_tready = w_en;
  assign w_accept      = s_axis_tvalid && w_en;
  assign w_x           = s_axis_tdata[SIG_W-1:0];
  assign w_unused_hi   = ^s_axis_tdata[DATA_W-1:SIG_W];

  deriv5_core #(
    .SIG_W           (SIG_W),
    .SUPPRESS_WARMUP (SUPPRESS_WARMUP)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_accept (w_accept),
    .i_x      (w_x),
    .o_d      (w_d),
    .o_v      (w_v1)
  );

  assign w_prod = (2*SIG_W)'(w_d) * (2*SIG_W)'(w_d);

  // S2 register: square of the derivative, always non-negative.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sq <= '0;
      r_v2 <= 1'b0;
    end else if (w_en) begin
      r_sq <= $unsigned(w_prod);
      r_v2 <= w_v1;
    end
  end

  // Output register: holds data and valid while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (w_en) begin
      r_tdata  <= DATA_W'(r_sq);
      r_tvalid <= r_v2;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_derivative_square.sv
// Directed bench for axis_derivative_square.
// Each task drives one scenario and checks its own results.
module tb_axis_derivative_square;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  int total = 0;
  int bad   = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  axis_derivative_square #(
    .DATA_W          (32),
    .SIG_W           (16),
    .SUPPRESS_WARMUP (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // Output beats: inputs change just after posedge, so the
  // negedge view is what the next posedge handshake sees.
  always @(negedge clk)
    if (m_axis_tvalid && m_axis_tready)
      got.push_back(m_axis_tdata);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Offer one sample and return just after the edge that took it.
  task automatic send(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = v;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis_tready;
      step();
    end
    s_axis_tvalid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_accept: tready never seen for %h", v);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    idle(3);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    idle(8);
  endtask

  task automatic wait_tvalid(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_axis_tvalid;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: tvalid got 0 want 1", nm);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid);
    end
    total++;
    if (m_axis_tdata !== 32'd0) begin
      bad++;
      $display("FAIL rst_tdata: got %0d want 0", m_axis_tdata);
    end
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL rst_sready: got %b want 1", s_axis_tready);
    end
    step();
  endtask

  task automatic test_constant();
    logic exp_v;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      send(32'd100);
      exp_v = (n >= 4);
      @(negedge clk);
      total++;
      if (m_axis_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL const_lat1 n=%0d: got %b want 0", n, m_axis_tvalid);
      end
      @(negedge clk);
      total++;
      if (m_axis_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL const_lat2 n=%0d: got %b want 0", n, m_axis_tvalid);
      end
      @(negedge clk);
      total++;
      if (m_axis_tvalid !== exp_v) begin
        bad++;
        $display("FAIL const_lat3 n=%0d: got %b want %b", n, m_axis_tvalid, exp_v);
      end
      idle(3);
    end
    drain();
    total++;
    if (got.size() != 6) begin
      bad++;
      $display("FAIL const_count: got %0d want 6", got.size());
    end
    foreach (got[i]) begin
      total++;
      if (got[i] !== 32'd0) begin
        bad++;
        $display("FAIL const_data[%0d]: got %0d want 0", i, got[i]);
      end
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int n = 0; n < 12; n++) begin
      send(32'(8 * n));
      idle(4);
    end
    drain();
    total++;
    if (got.size() != 8) begin
      bad++;
      $display("FAIL ramp_count: got %0d want 8", got.size());
    end
    foreach (got[i]) begin
      total++;
      if (got[i] !== 32'd100) begin
        bad++;
        $display("FAIL ramp_data[%0d]: got %0d want 100", i, got[i]);
      end
    end
  endtask

  task automatic test_alternating();
    int nz;
    do_reset();
    for (int n = 0; n < 100; n++) begin
      send((n % 2) ? 32'd3 : 32'd5);
      idle(1);
    end
    drain();
    nz = 0;
    foreach (got[i]) if (got[i] != 0) nz++;
    total++;
    if (got.size() != 96) begin
      bad++;
      $display("FAIL alt_count: got %0d want 96", got.size());
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL alt_nonzero: got %0d want 0", nz);
    end
  endtask

  task automatic test_step();
    logic [31:0] exp_q[$];
    exp_q = '{32'd0, 32'd40000, 32'd90000, 32'd90000, 32'd40000,
              32'd0, 32'd160000, 32'd360000, 32'd360000,
              32'd160000, 32'd0};
    do_reset();
    for (int n = 0; n < 5; n++) begin send(32'd0); idle(2); end
    for (int n = 0; n < 5; n++) begin send(32'd800); idle(2); end
    for (int n = 0; n < 5; n++) begin send(-32'sd800); idle(2); end
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL step_count: got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL step_data[%0d]: got %0d want %0d", i,
                 (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    send(32'h0000_8000); idle(2);
    send(32'h0000_8000); idle(2);
    send(32'h0000_0000); idle(2);
    send(32'h0000_7FFF); idle(2);
    send(32'h0000_7FFF);
    drain();
    total++;
    if (got.size() != 1 || got[0] !== 32'd603930625) begin
      bad++;
      $display("FAIL max_mag: got n=%0d v=%0d want 603930625",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
    do_reset();
    for (int n = 0; n < 4; n++) begin send(32'hFFFF_0000); idle(2); end
    send(32'h1234_FFFF);
    drain();
    total++;
    if (got.size() != 1 || got[0] !== 32'd1) begin
      bad++;
      $display("FAIL floor_neg: got n=%0d v=%0d want 1",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int n = 0; n < 4; n++) begin send(32'd0); idle(2); end
    send(32'd800);
    m_axis_tready = 1'b0;
    wait_tvalid("bp_pending");
    s_axis_tdata  = 32'd800;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      total++;
      if (m_axis_tdata !== 32'd40000 || s_axis_tready !== 1'b0 ||
          m_axis_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold c=%0d: got d=%0d sr=%b v=%b want 40000/0/1",
                 c, m_axis_tdata, s_axis_tready, m_axis_tvalid);
      end
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got sready %b want 1", s_axis_tready);
    end
    step();
    drain();
    total++;
    if (got.size() != 2 || got[0] !== 32'd40000 || got[1] !== 32'd90000) begin
      bad++;
      $display("FAIL bp_beats: got n=%0d first=%0d second=%0d want 40000,90000",
               got.size(), (got.size() > 0) ? got[0] : 32'hx,
               (got.size() > 1) ? got[1] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[40];
    logic [31:0] exp_q[$];
    int h1, h2, h3, h4, x, s, q, idx, nacc;
    do_reset();
    foreach (vals[i]) vals[i] = $urandom;
    h1 = 0; h2 = 0; h3 = 0; h4 = 0; idx = 0; nacc = 0;
    s_axis_tdata  = vals[0];
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 2000 && idx < 40; cyc++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        x = int'($signed(vals[idx][15:0]));
        s = 2 * x + h1 - h3 - 2 * h4;
        q = s / 8;
        if (s < 0 && (s % 8) != 0) q = q - 1;
        if (nacc >= 4) exp_q.push_back(32'(q * q));
        h4 = h3; h3 = h2; h2 = h1; h1 = x;
        nacc++;
        idx++;
      end
      @(posedge clk);
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
      if (idx < 40) s_axis_tdata = vals[idx];
      else s_axis_tvalid = 1'b0;
    end
    total++;
    if (idx != 40) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d want 40", idx);
    end
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_data[%0d]: got %0d want %0d", i,
                 (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int n = 0; n < 4; n++) begin send(32'd0); idle(2); end
    send(32'd800);
    m_axis_tready = 1'b0;
    wait_tvalid("mid_pending");
    @(posedge clk);
    #1;
    idle(2);
    rst           = 1'b1;
    s_axis_tdata  = 32'd5000;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL mid_stalled: got tvalid %b want 1", m_axis_tvalid);
    end
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 ||
        s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: got v=%b d=%0d sr=%b want 0/0/1",
               m_axis_tvalid, m_axis_tdata, s_axis_tready);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int n = 0; n < 4; n++) begin send(32'd0); idle(3); end
    total++;
    if (got.size() != 0) begin
      bad++;
      $display("FAIL mid_warmup: got %0d beats want 0", got.size());
    end
    send(32'd8);
    drain();
    total++;
    if (got.size() != 1 || got[0] !== 32'd4) begin
      bad++;
      $display("FAIL mid_fifth: got n=%0d v=%0d want 4",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_constant();
    test_ramp();
    test_alternating();
    test_step();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
